// File: rtl/error_exc_ctrl_pkg.sv
// Shared types and constants for the CP0 error-level exception sequencer:
// FSM states, cause codes and the redirect vectors.
package error_exc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FLUSH    = 3'd1,
      ST_CAPTURE  = 3'd2,
      ST_REDIRECT = 3'd3,
      ST_ERL      = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE      = 2'd0,
      CAUSE_SOFT_RST  = 2'd1,
      CAUSE_NMI       = 2'd2,
      CAUSE_CACHE_ERR = 2'd3
   } cause_e;

   localparam logic [31:0] VEC_RESET         = 32'hBFC0_0000;
   localparam logic [31:0] VEC_CACHE_ERR_BEV = 32'hBFC0_0300;
   localparam logic [31:0] VEC_CACHE_ERR     = 32'hA000_0100;

   function automatic logic [31:0] vector_for(input cause_e c, input logic bev);
      if (c == CAUSE_CACHE_ERR) return bev ? VEC_CACHE_ERR_BEV : VEC_CACHE_ERR;
      return VEC_RESET;
   endfunction

endpackage

// File: rtl/error_exc_ctrl_req_arb.sv
// Sticky pending latches for the three error requests plus a fixed-priority
// select (soft reset > NMI > cache error); deq retires the selected cause.
module error_req_arb
   import error_exc_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   soft_rst_req,
   input  logic   nmi_req,
   input  logic   cache_err_req,
   input  logic   deq,
   output cause_e sel
);

   logic [2:0] req_vec;
   logic [2:0] avail;
   logic [2:0] clr;
   logic [2:0] pend_q, pend_d;

   // Incoming pulses are visible to the select in the same cycle, so an
   // idle sequencer reacts without waiting for the latch.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      req_vec = {cache_err_req, nmi_req, soft_rst_req};
      avail   = pend_q | req_vec;
      sel     = CAUSE_NONE;
      clr     = 3'b000;
      if (avail[0]) begin
         sel = CAUSE_SOFT_RST;
         clr = 3'b001;
      end else if (avail[1]) begin
         sel = CAUSE_NMI;
         clr = 3'b010;
      end else if (avail[2]) begin
         sel = CAUSE_CACHE_ERR;
         clr = 3'b100;
      end
      if (!deq) clr = 3'b000;
      // A retired bit that was already latched stays set if a fresh pulse
      // of the same kind arrives in the dequeue cycle.
      for (int i = 0; i < 3; i++) begin
         pend_d[i] = clr[i] ? (pend_q[i] & req_vec[i]) : avail[i];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) pend_q <= 3'b000;
      else     pend_q <= pend_d;
   end

endmodule

// File: rtl/error_exc_ctrl.sv
// CP0 error-level exception sequencer: flushes the pipeline, strobes the
// ErrorEPC capture, redirects to the error vector and owns Status.ERL.
module error_exc_ctrl
   import error_exc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        soft_rst_req,
   input  logic        nmi_req,
   input  logic        cache_err_req,
   input  logic [31:0] pc_p,
   input  logic        bd_p,
   input  logic        valid_p,
   input  logic        bev,
   input  logic        eret,
   input  logic        flush_ack,
   output logic        flush_req,
   output logic        epc_r_h,
   output logic        epc_cache_err,
   output logic [31:0] epc_pc,
   output logic        epc_bd,
   output logic        erl,
   output logic        vec_valid,
   output logic [31:0] vec_addr,
   output logic [1:0]  cause,
   output logic        busy
);

   state_e      state_q, state_d;
   cause_e      sel_cause;
   cause_e      cause_lock_q, cause_lock_d;
   logic        deq;
   logic        capture;
   logic [31:0] pc_hold_q;
   logic        bd_hold_q;

   logic        flush_req_q, flush_req_d;
   logic        epc_r_h_q, epc_r_h_d;
   logic        epc_cache_err_q, epc_cache_err_d;
   logic [31:0] epc_pc_q, epc_pc_d;
   logic        epc_bd_q, epc_bd_d;
   logic        erl_q, erl_d;
   logic        vec_valid_q, vec_valid_d;
   logic [31:0] vec_addr_q, vec_addr_d;
   cause_e      cause_q, cause_d;

   error_req_arb u_arb (
      .clk           (clk),
      .rst           (rst),
      .soft_rst_req  (soft_rst_req),
      .nmi_req       (nmi_req),
      .cache_err_req (cache_err_req),
      .deq           (deq),
      .sel           (sel_cause)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cause_lock_q <= CAUSE_NONE;
      end else begin
         state_q      <= state_d;
         cause_lock_q <= cause_lock_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cause_lock_d = cause_lock_q;
      deq          = 1'b0;
      case (state_q)
         ST_IDLE: if (sel_cause != CAUSE_NONE) begin
            state_d      = ST_FLUSH;
            cause_lock_d = sel_cause;
            deq          = 1'b1;
         end
         ST_FLUSH:    if (flush_ack) state_d = ST_CAPTURE;
         ST_CAPTURE:  state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_ERL;
         // Soft reset / NMI preempt ERL even alongside ERET; cache error waits.
         ST_ERL: if (sel_cause == CAUSE_SOFT_RST || sel_cause == CAUSE_NMI) begin
            state_d      = ST_FLUSH;
            cause_lock_d = sel_cause;
            deq          = 1'b1;
         end else if (eret) begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      capture         = (state_q == ST_FLUSH) && flush_ack;
      flush_req_d     = (state_d == ST_FLUSH);
      epc_r_h_d       = (state_d == ST_CAPTURE) && (cause_lock_q != CAUSE_CACHE_ERR);
      epc_cache_err_d = (state_d == ST_CAPTURE) && (cause_lock_q == CAUSE_CACHE_ERR);
      vec_valid_d     = (state_d == ST_REDIRECT);
      erl_d           = erl_q;
      if (state_q == ST_REDIRECT)                           erl_d = 1'b1;
      else if (state_q == ST_ERL && state_d == ST_IDLE)     erl_d = 1'b0;
      epc_pc_d   = epc_pc_q;
      epc_bd_d   = epc_bd_q;
      cause_d    = cause_q;
      vec_addr_d = vec_addr_q;
      if (capture) begin
         epc_pc_d   = valid_p ? pc_p : pc_hold_q;
         epc_bd_d   = valid_p ? bd_p : bd_hold_q;
         cause_d    = cause_lock_q;
         vec_addr_d = vector_for(cause_lock_q, bev);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_hold_q       <= 32'h0;
         bd_hold_q       <= 1'b0;
         flush_req_q     <= 1'b0;
         epc_r_h_q       <= 1'b0;
         epc_cache_err_q <= 1'b0;
         epc_pc_q        <= 32'h0;
         epc_bd_q        <= 1'b0;
         erl_q           <= 1'b0;
         vec_valid_q     <= 1'b0;
         vec_addr_q      <= 32'h0;
         cause_q         <= CAUSE_NONE;
      end else begin
         if (valid_p) begin
            pc_hold_q <= pc_p;
            bd_hold_q <= bd_p;
         end
         flush_req_q     <= flush_req_d;
         epc_r_h_q       <= epc_r_h_d;
         epc_cache_err_q <= epc_cache_err_d;
         epc_pc_q        <= epc_pc_d;
         epc_bd_q        <= epc_bd_d;
         erl_q           <= erl_d;
         vec_valid_q     <= vec_valid_d;
         vec_addr_q      <= vec_addr_d;
         cause_q         <= cause_d;
      end
   end

   assign flush_req     = flush_req_q;
   assign epc_r_h       = epc_r_h_q;
   assign epc_cache_err = epc_cache_err_q;
   assign epc_pc        = epc_pc_q;
   assign epc_bd        = epc_bd_q;
   assign erl           = erl_q;
   assign vec_valid     = vec_valid_q;
   assign vec_addr      = vec_addr_q;
   assign cause         = cause_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_error_exc_ctrl.sv
// Directed bench for error_exc_ctrl with hand-computed expectations.
module tb_error_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        soft_rst_req = 1'b0, nmi_req = 1'b0, cache_err_req = 1'b0;
   logic [31:0] pc_p = 32'h0;
   logic        bd_p = 1'b0, valid_p = 1'b0, bev = 1'b0, eret = 1'b0, flush_ack = 1'b0;
   logic        flush_req, epc_r_h, epc_cache_err, epc_bd, erl, vec_valid, busy;
   logic [31:0] epc_pc, vec_addr;
   logic [1:0]  cause;

   int n_checks = 0;
   int n_pass   = 0;

   error_exc_ctrl dut (
      .clk(clk), .rst(rst),
      .soft_rst_req(soft_rst_req), .nmi_req(nmi_req), .cache_err_req(cache_err_req),
      .pc_p(pc_p), .bd_p(bd_p), .valid_p(valid_p), .bev(bev), .eret(eret),
      .flush_ack(flush_ack), .flush_req(flush_req), .epc_r_h(epc_r_h),
      .epc_cache_err(epc_cache_err), .epc_pc(epc_pc), .epc_bd(epc_bd), .erl(erl),
      .vec_valid(vec_valid), .vec_addr(vec_addr), .cause(cause), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".flush_req"}, 32'(flush_req), 32'h0);
      check({tag, ".strobes"},   32'({epc_r_h, epc_cache_err, vec_valid}), 32'h0);
      check({tag, ".epc_pc"},    epc_pc, 32'h0);
      check({tag, ".epc_bd"},    32'(epc_bd), 32'h0);
      check({tag, ".erl"},       32'(erl), 32'h0);
      check({tag, ".vec_addr"},  vec_addr, 32'h0);
      check({tag, ".cause"},     32'(cause), 32'h0);
      check({tag, ".busy"},      32'(busy), 32'h0);
   endtask

   // Called in a FLUSH cycle: acks, then walks CAPTURE, REDIRECT and ERL entry.
   task automatic finish_seq(input string tag, input logic is_cache, input logic [31:0] pc,
                             input logic bd, input logic [31:0] vec, input logic [1:0] cs);
      flush_ack = 1'b1;
      step();
      flush_ack = 1'b0;
      check({tag, ".r_h"},       32'(epc_r_h), 32'(!is_cache));
      check({tag, ".cache_err"}, 32'(epc_cache_err), 32'(is_cache));
      check({tag, ".flush_off"}, 32'(flush_req), 32'h0);
      check({tag, ".epc_pc"},    epc_pc, pc);
      check({tag, ".epc_bd"},    32'(epc_bd), 32'(bd));
      check({tag, ".cause"},     32'(cause), 32'(cs));
      check({tag, ".vec_addr"},  vec_addr, vec);
      step();
      check({tag, ".vec_valid"}, 32'(vec_valid), 32'h1);
      check({tag, ".strobe_off"}, 32'({epc_r_h, epc_cache_err}), 32'h0);
      step();
      check({tag, ".erl"},       32'(erl), 32'h1);
      check({tag, ".vec_off"},   32'(vec_valid), 32'h0);
      check({tag, ".busy"},      32'(busy), 32'h1);
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      check_all_zero("reset");

      // Cache error, bev=1, flush_ack one cycle after FLUSH entry.
      cache_err_req = 1'b1; bev = 1'b1; pc_p = 32'h4; valid_p = 1'b1; bd_p = 1'b0;
      step();
      cache_err_req = 1'b0;
      check("ce1.flush_req", 32'(flush_req), 32'h1);
      finish_seq("ce1", 1'b1, 32'h4, 1'b0, 32'hBFC0_0300, 2'd3);

      // Soft reset preempts ERL even with a simultaneous eret.
      soft_rst_req = 1'b1; eret = 1'b1; pc_p = 32'h200;
      step();
      soft_rst_req = 1'b0; eret = 1'b0;
      check("pre.flush_req", 32'(flush_req), 32'h1);
      check("pre.erl_held",  32'(erl), 32'h1);
      finish_seq("pre", 1'b0, 32'h200, 1'b0, 32'hBFC0_0000, 2'd1);
      eret = 1'b1;
      step();
      eret = 1'b0;
      check("pre.eret_erl",  32'(erl), 32'h0);
      check("pre.eret_busy", 32'(busy), 32'h0);

      // Latency with ack at cycle 2, bev=0, branch delay slot.
      cache_err_req = 1'b1; bev = 1'b0; bd_p = 1'b1; pc_p = 32'h8;
      step();
      cache_err_req = 1'b0;
      check("lat.flush_c1", 32'(flush_req), 32'h1);
      step();
      check("lat.flush_c2", 32'(flush_req), 32'h1);
      finish_seq("ce0", 1'b1, 32'h8, 1'b1, 32'hA000_0100, 2'd3);
      eret = 1'b1;
      step();
      eret = 1'b0;
      check("ce0.eret_erl", 32'(erl), 32'h0);

      // NMI and cache error together: NMI first, cache error after eret.
      nmi_req = 1'b1; cache_err_req = 1'b1; pc_p = 32'h10; bd_p = 1'b0;
      step();
      nmi_req = 1'b0; cache_err_req = 1'b0;
      check("nmi.flush_req", 32'(flush_req), 32'h1);
      finish_seq("nmi", 1'b0, 32'h10, 1'b0, 32'hBFC0_0000, 2'd2);
      pc_p = 32'h100; bd_p = 1'b1;
      step();
      check("ce_wait.flush", 32'(flush_req), 32'h0);
      check("ce_wait.erl",   32'(erl), 32'h1);
      valid_p = 1'b0; pc_p = 32'hDEAD_BEEF; bd_p = 1'b0; eret = 1'b1;
      step();
      eret = 1'b0;
      check("ce_idle.erl",   32'(erl), 32'h0);
      check("ce_idle.busy",  32'(busy), 32'h0);
      check("ce_idle.flush", 32'(flush_req), 32'h0);
      step();
      check("ce_auto.flush", 32'(flush_req), 32'h1);
      finish_seq("hold", 1'b1, 32'h100, 1'b1, 32'hA000_0100, 2'd3);
      eret = 1'b1;
      step();
      eret = 1'b0;

      // Reset mid-FLUSH with an NMI pending.
      soft_rst_req = 1'b1;
      step();
      soft_rst_req = 1'b0;
      check("rst.flush_before", 32'(flush_req), 32'h1);
      nmi_req = 1'b1;
      step();
      nmi_req = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_all_zero("rst_mid");
      step();
      step();
      check("rst.pend_flush", 32'(flush_req), 32'h0);
      check("rst.pend_busy",  32'(busy), 32'h0);

      // ERET with erl=0 is ignored.
      eret = 1'b1;
      step();
      eret = 1'b0;
      check("eret0.erl",  32'(erl), 32'h0);
      check("eret0.busy", 32'(busy), 32'h0);
      check("eret0.vec",  32'(vec_valid), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
